// File: rtl/slave_port_if.sv
// Bit-serial slave bus: serial address/data with phase control, plus ready/response back channel.
interface slave_port_if;
  logic       s_select;
  logic [1:0] s_trans;
  logic       s_addr;
  logic       s_write;
  logic       s_wdata;
  logic       s_rdata;
  logic       s_ready;
  logic [1:0] s_resp;

  modport master (output s_select, s_trans, s_addr, s_write, s_wdata,
                  input  s_rdata, s_ready, s_resp);
  modport slave  (input  s_select, s_trans, s_addr, s_write, s_wdata,
                  output s_rdata, s_ready, s_resp);
endinterface

// File: rtl/slave_port.sv
// Bit-serial memory slave: shifts in an address and write word, or shifts out a read word,
// then reports OKAY/ERROR for one cycle. All bus outputs come straight from flops.
module slave_port #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 3072
) (
  input  logic        clk,
  input  logic        reset,
  slave_port_if.slave bus
);
  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_ADDR   = 2'b01;
  localparam logic [1:0] TR_DATA   = 2'b10;
  localparam logic [1:0] TR_RSVD   = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RFETCH, RDATA, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] wsh_q, wsh_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic [1:0]        resp_d;
  logic              ready_q, rdata_q;
  logic [1:0]        resp_q;
  logic              in_range_c, mem_we_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign in_range_c = ({1'b0, addr_q} < (ADDR_W+1)'(MEM_DEPTH));
  assign idx_c      = addr_q[IDX_W-1:0];

  assign bus.s_ready = ready_q;
  assign bus.s_rdata = rdata_q;
  assign bus.s_resp  = resp_q;

  // Next-state, shift and memory-write decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    wsh_d    = wsh_q;
    rsh_d    = rsh_q;
    resp_d   = RESP_OKAY;
    mem_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_select && bus.s_trans == TR_ADDR) begin
          addr_d  = ADDR_W'(bus.s_addr);
          wr_d    = bus.s_write;
          cnt_d   = CNT_W'(ADDR_W - 2);
          state_d = ADDR;
        end else if (bus.s_select && bus.s_trans == TR_RSVD) begin
          resp_d  = RESP_ERR;
          state_d = RESP;
        end
      end
      ADDR: begin
        if (!bus.s_select) begin
          state_d = IDLE;
        end else if (bus.s_trans == TR_ADDR) begin
          addr_d = ADDR_W'({addr_q, bus.s_addr});
          if (cnt_q == '0) begin
            cnt_d   = CNT_W'(DATA_W - 1);
            state_d = wr_q ? WDATA : RFETCH;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (bus.s_trans != TR_IDLE) begin
          resp_d  = RESP_ERR;
          state_d = RESP;
        end
      end
      WDATA: begin
        if (!bus.s_select) begin
          state_d = IDLE;
        end else if (bus.s_trans == TR_DATA) begin
          wsh_d = DATA_W'({wsh_q, bus.s_wdata});
          if (cnt_q == '0) begin
            mem_we_c = in_range_c;
            resp_d   = in_range_c ? RESP_OKAY : RESP_ERR;
            state_d  = RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (bus.s_trans != TR_IDLE) begin
          resp_d  = RESP_ERR;
          state_d = RESP;
        end
      end
      RFETCH: begin
        if (!bus.s_select) begin
          state_d = IDLE;
        end else if (bus.s_trans == TR_RSVD) begin
          resp_d  = RESP_ERR;
          state_d = RESP;
        end else begin
          rsh_d   = in_range_c ? mem[idx_c] : '0;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (!bus.s_select) begin
          state_d = IDLE;
        end else if (bus.s_trans == TR_DATA) begin
          rsh_d = DATA_W'({rsh_q, 1'b0});
          if (cnt_q == '0) begin
            resp_d  = in_range_c ? RESP_OKAY : RESP_ERR;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (bus.s_trans != TR_IDLE) begin
          resp_d  = RESP_ERR;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE || state_d == RESP) cnt_d = '0;
  end

  // State and registered bus outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      wsh_q   <= '0;
      rsh_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= 1'b0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      wsh_q   <= wsh_d;
      rsh_q   <= rsh_d;
      ready_q <= (state_d != RFETCH);
      rdata_q <= (state_d == RDATA) ? rsh_d[DATA_W-1] : 1'b0;
      resp_q  <= (state_d == RESP) ? resp_d : RESP_OKAY;
    end
  end

  // Storage is never cleared; reset on the final data edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we_c && !reset) mem[idx_c] <= wsh_d;
  end
endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: write/read, range, abort, stall, reset and protocol-error cases.
module tb_slave_port;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   last_ticks;
  logic last_fetch_ready;

  slave_port_if bus();

  slave_port #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(3072)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic sel, input logic [1:0] tr, input logic a,
                        input logic w, input logic wd);
    bus.s_select = sel;
    bus.s_trans  = tr;
    bus.s_addr   = a;
    bus.s_write  = w;
    bus.s_wdata  = wd;
  endtask

  // s_write is inverted after the first beat: only the first beat may count.
  task automatic send_addr(input logic wr, input logic [AW-1:0] a, input int stall_at,
                           input int stall_n);
    last_ticks = 0;
    for (int i = 0; i < int'(AW); i++) begin
      if (i == stall_at)
        for (int k = 0; k < stall_n; k++) begin
          set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick(); last_ticks++;
        end
      set_in(1'b1, 2'b01, a[AW-1-i], (i == 0) ? wr : ~wr, 1'b0);
      tick(); last_ticks++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic [1:0] resp);
    send_addr(1'b1, a, -1, 0);
    for (int i = 0; i < int'(DW); i++) begin
      set_in(1'b1, 2'b10, 1'b0, 1'b0, d[DW-1-i]); tick(); last_ticks++;
    end
    resp = bus.s_resp;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int sa_at, input int sa_n,
                         input int sd_at, input int sd_n,
                         output logic [DW-1:0] data, output logic [1:0] resp);
    send_addr(1'b0, a, sa_at, sa_n);
    last_fetch_ready = bus.s_ready;
    set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick(); last_ticks++;
    data = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (i == sd_at)
        for (int k = 0; k < sd_n; k++) begin
          set_in(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick(); last_ticks++;
        end
      data = {data[DW-2:0], bus.s_rdata};
      set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick(); last_ticks++;
    end
    resp = bus.s_resp;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    compared++; if (bus.s_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b want 0", bus.s_ready); end
    compared++; if (bus.s_rdata !== 1'b0) begin mismatched++; $display("FAIL rst_rdata: got %b want 0", bus.s_rdata); end
    compared++; if (bus.s_resp !== 2'b00) begin mismatched++; $display("FAIL rst_resp: got %b want 00", bus.s_resp); end
    reset = 1'b0;
    tick();
    compared++; if (bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_write_read();
    logic [1:0] r; logic [DW-1:0] d;
    do_write(12'h010, 8'hA5, r);
    compared++; if (r !== 2'b00) begin mismatched++; $display("FAIL wr_a5_resp: got %b want 00", r); end
    compared++; if (last_ticks !== 20) begin mismatched++; $display("FAIL wr_latency: got %0d want 20", last_ticks); end
    compared++; if (bus.s_resp !== 2'b00 || bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL idle_after_wr: resp %b ready %b want 00/1", bus.s_resp, bus.s_ready); end
    do_read(12'h010, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'hA5) begin mismatched++; $display("FAIL rd_a5_data: got %h want a5", d); end
    compared++; if (r !== 2'b00) begin mismatched++; $display("FAIL rd_a5_resp: got %b want 00", r); end
    compared++; if (last_fetch_ready !== 1'b0) begin mismatched++; $display("FAIL rfetch_ready: got %b want 0", last_fetch_ready); end
    compared++; if (last_ticks !== 21) begin mismatched++; $display("FAIL rd_latency: got %0d want 21", last_ticks); end
    compared++; if (bus.s_rdata !== 1'b0) begin mismatched++; $display("FAIL idle_rdata: got %b want 0", bus.s_rdata); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [DW-1:0] d;
    do_write(12'h000, 8'h77, r);
    do_write(12'hBFF, 8'h5A, r);
    compared++; if (r !== 2'b00) begin mismatched++; $display("FAIL wr_last_resp: got %b want 00", r); end
    do_read(12'hC00, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h00) begin mismatched++; $display("FAIL rd_oor_data: got %h want 00", d); end
    compared++; if (r !== 2'b01) begin mismatched++; $display("FAIL rd_oor_resp: got %b want 01", r); end
    do_write(12'hC00, 8'h3C, r);
    compared++; if (r !== 2'b01) begin mismatched++; $display("FAIL wr_oor_resp: got %b want 01", r); end
    do_read(12'hFFF, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h00 || r !== 2'b01) begin mismatched++; $display("FAIL rd_fff: data %h resp %b want 00/01", d, r); end
    do_read(12'hBFF, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h5A || r !== 2'b00) begin mismatched++; $display("FAIL rd_bff: data %h resp %b want 5a/00", d, r); end
    do_read(12'h000, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h77) begin mismatched++; $display("FAIL rd_000_after_oor: got %h want 77", d); end
  endtask

  task automatic test_abort();
    logic [1:0] r; logic [DW-1:0] d;
    logic [AW-1:0] a;
    a = 12'h030;
    do_write(a, 8'h42, r);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'b01, a[AW-1-i], 1'b1, 1'b0); tick();
    end
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    compared++; if (bus.s_resp !== 2'b00 || bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL abort_addr_out: resp %b ready %b want 00/1", bus.s_resp, bus.s_ready); end
    do_read(a, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h42 || r !== 2'b00) begin mismatched++; $display("FAIL abort_addr_rd: data %h resp %b want 42/00", d, r); end
    send_addr(1'b1, a, -1, 0);
    for (int i = 0; i < int'(DW) - 1; i++) begin
      set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b1); tick();
    end
    set_in(1'b0, 2'b10, 1'b0, 1'b0, 1'b1); tick();
    compared++; if (bus.s_resp !== 2'b00) begin mismatched++; $display("FAIL abort_data_resp: got %b want 00", bus.s_resp); end
    do_read(a, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h42) begin mismatched++; $display("FAIL abort_data_rd: got %h want 42", d); end
  endtask

  task automatic test_stall();
    logic [1:0] r; logic [DW-1:0] d;
    do_read(12'h010, 4, 3, 3, 2, d, r);
    compared++; if (d !== 8'hA5) begin mismatched++; $display("FAIL stall_data: got %h want a5", d); end
    compared++; if (r !== 2'b00) begin mismatched++; $display("FAIL stall_resp: got %b want 00", r); end
    compared++; if (last_ticks !== 26) begin mismatched++; $display("FAIL stall_latency: got %0d want 26", last_ticks); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [DW-1:0] d;
    do_write(12'h020, 8'h11, r);
    send_addr(1'b1, 12'h020, -1, 0);
    for (int i = 0; i < int'(DW) - 1; i++) begin
      set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b1); tick();
    end
    set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    compared++; if (bus.s_ready !== 1'b0 || bus.s_rdata !== 1'b0 || bus.s_resp !== 2'b00) begin mismatched++; $display("FAIL mid_rst_outputs: ready %b rdata %b resp %b want 0/0/00", bus.s_ready, bus.s_rdata, bus.s_resp); end
    reset = 1'b0;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    compared++; if (bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL mid_rst_ready: got %b want 1", bus.s_ready); end
    do_read(12'h020, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h11) begin mismatched++; $display("FAIL mid_rst_rd: got %h want 11", d); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; logic [DW-1:0] d;
    logic [AW-1:0] a;
    a = 12'h040;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'b01, a[AW-1-i], 1'b1, 1'b0); tick();
    end
    set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick();
    compared++; if (bus.s_resp !== 2'b01 || bus.s_ready !== 1'b1) begin mismatched++; $display("FAIL proto_resp: resp %b ready %b want 01/1", bus.s_resp, bus.s_ready); end
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    compared++; if (bus.s_resp !== 2'b00) begin mismatched++; $display("FAIL proto_one_cycle: got %b want 00", bus.s_resp); end
    do_write(a, 8'h99, r);
    compared++; if (r !== 2'b00) begin mismatched++; $display("FAIL b2b_wr_resp: got %b want 00", r); end
    send_addr(1'b1, a, -1, 0);
    set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0); tick();
    compared++; if (bus.s_resp !== 2'b01) begin mismatched++; $display("FAIL rsvd_resp: got %b want 01", bus.s_resp); end
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    do_read(a, -1, 0, -1, 0, d, r);
    compared++; if (d !== 8'h99 || r !== 2'b00) begin mismatched++; $display("FAIL b2b_rd: data %h resp %b want 99/00", d, r); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_abort();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
